// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Imported by fetch_ctrl and its instruction queue.
package fetch_ctrl_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    localparam logic [WIDTH-1:0] PC_INC = 16'd2;
    localparam logic [WIDTH-1:0] NOP    = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_WAIT = 2'b01,
        FS_DROP = 2'b10
    } fstate_e;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc2;
    } qent_t;

    function automatic logic [WIDTH-1:0] pc_add(input logic [WIDTH-1:0] p);
        return p + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// Two-entry instruction/PC+inc queue between fetch and decode.
// Flush wins over push and pop; head reads as zero when empty.
module inst_queue2
    import fetch_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  logic  flush_i,
    input  qent_t push_data_i,
    output qent_t head_o,
    output logic  valid_o,
    output logic  full_o
);

    qent_t      ent_q [DEPTH];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       wr_en;

    assign wr_en = push_i && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data banks are plain enabled registers; contents are masked while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (wr_en) begin
            ent_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'(DEPTH));
    assign head_o  = valid_o ? ent_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one memory read at a time, queues returned
// instructions, steers the external PC register and handles redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_en,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_stall,
    input  logic             mem_done,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc2,
    output logic             inst_valid,
    input  logic             dec_ready
);

    fstate_e          state_q, state_d;
    logic [WIDTH-1:0] pc_inc;
    logic             q_push;
    logic             q_pop;
    logic             q_flush;
    logic             q_valid;
    logic             q_full;
    qent_t            q_head;
    qent_t            q_wdata;

    assign pc_inc   = pc_add(pc);
    assign mem_addr = pc;
    assign q_wdata  = '{inst: mem_data, pc2: pc_inc};

    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        pc_next = pc_inc;
        mem_rd  = 1'b0;
        q_push  = 1'b0;
        q_flush = 1'b0;
        if (rst) begin
            state_d = FS_IDLE;
        end else if (redirect) begin
            pc_en   = 1'b1;
            pc_next = redirect_pc;
            q_flush = 1'b1;
            // A read still in flight must be swallowed unless it ends now.
            unique case (state_q)
                FS_WAIT: state_d = mem_done ? FS_IDLE : FS_DROP;
                FS_DROP: state_d = mem_done ? FS_IDLE : FS_DROP;
                default: state_d = FS_IDLE;
            endcase
        end else begin
            unique case (state_q)
                FS_IDLE: begin
                    mem_rd = !q_full;
                    if (!q_full && !mem_stall) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (mem_done) begin
                        q_push  = 1'b1;
                        pc_en   = 1'b1;
                        state_d = FS_IDLE;
                    end
                end
                FS_DROP: begin
                    if (mem_done) begin
                        state_d = FS_IDLE;
                    end
                end
                default: state_d = FS_IDLE;
            endcase
        end
    end

    assign q_pop = !rst && !redirect && q_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    inst_queue2 u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (q_push),
        .pop_i       (q_pop),
        .flush_i     (q_flush),
        .push_data_i (q_wdata),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .full_o      (q_full)
    );

    assign inst_valid = q_valid && !rst;
    assign inst       = inst_valid ? q_head.inst : NOP;
    assign inst_pc2   = inst_valid ? q_head.pc2 : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register, a latency/stall
// memory model and a queue scoreboard of expected decoded instructions.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_data;
    logic [15:0] inst;
    logic [15:0] inst_pc2;
    logic        inst_valid;
    logic        dec_ready;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pc <= 16'h0000;
        else if (pc_en) pc <= pc_next;
    end

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .mem_data    (mem_data),
        .inst        (inst),
        .inst_pc2    (inst_pc2),
        .inst_valid  (inst_valid),
        .dec_ready   (dec_ready)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    qent_t       sb[$];
    logic        pend, pend_want;
    logic [15:0] pend_addr, exp_pc;
    int          lat, lat_cnt, stall_cnt;
    int          rd_cnt, pcen_cnt, n_pop;
    logic        seen_rd, last_valid;
    logic [15:0] seen_addr;

    function automatic logic [15:0] mval(input logic [15:0] a);
        return (a ^ 16'hC35A) + 16'h0123;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        qent_t       e;
        logic        acc;
        logic        done_now;
        logic [15:0] acc_addr;
        logic [15:0] nxt;
        @(negedge clk);
        acc      = 1'b0;
        acc_addr = exp_pc;
        done_now = mem_done;
        last_valid = inst_valid;
        if (rst) begin
            chk("rst_valid", inst_valid, 0);
            chk("rst_inst", inst, 0);
            chk("rst_pc2", inst_pc2, 0);
            chk("rst_rd", mem_rd, 0);
            chk("rst_pcen", pc_en, 0);
            sb.delete();
            pend = 1'b0;
            pend_want = 1'b0;
            exp_pc = 16'h0000;
        end else begin
            chk("valid", inst_valid, sb.size() != 0);
            if (sb.size() == 0) begin
                chk("empty_inst", inst, 0);
                chk("empty_pc2", inst_pc2, 0);
            end
            if (pend || sb.size() == 2 || redirect) chk("no_issue", mem_rd, 0);
            else chk("issue", mem_rd, 1);
            chk("pc_en", pc_en, redirect || (mem_done && pend && pend_want));
            if (mem_rd) begin
                rd_cnt++;
                if (!seen_rd) begin
                    seen_rd = 1'b1;
                    seen_addr = mem_addr;
                end
            end
            if (pc_en) pcen_cnt++;
            if (mem_rd && !mem_stall) begin
                chk("mem_addr", mem_addr, exp_pc);
                acc = 1'b1;
                acc_addr = exp_pc;
            end
            if (inst_valid && dec_ready && !redirect && sb.size() != 0) begin
                e = sb.pop_front();
                n_pop++;
                chk("pop_inst", inst, e.inst);
                chk("pop_pc2", inst_pc2, e.pc2);
            end
            if (mem_done && pend && pend_want && !redirect) begin
                nxt = pend_addr + 16'd2;
                chk("pc_next", pc_next, nxt);
                sb.push_back('{inst: mval(pend_addr), pc2: nxt});
                exp_pc = nxt;
            end
            if (redirect) begin
                chk("redir_pc", pc_next, redirect_pc);
                sb.delete();
                pend_want = 1'b0;
                exp_pc = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        if (done_now) pend = 1'b0;
        if (acc) begin
            pend = 1'b1;
            pend_want = 1'b1;
            pend_addr = acc_addr;
            lat_cnt = lat;
        end
        mem_done = 1'b0;
        mem_data = 16'($urandom);
        if (pend) begin
            if (lat_cnt <= 1) begin
                mem_done = 1'b1;
                mem_data = mval(pend_addr);
            end else begin
                lat_cnt--;
            end
        end
        mem_stall = (stall_cnt > 0);
        if (stall_cnt > 0) stall_cnt--;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 20 && (pend || mem_done); i++) cycle();
        chk(tag, pend || mem_done, 0);
    endtask

    task automatic wait_pend(input string tag);
        int i;
        for (i = 0; i < 20 && !pend; i++) cycle();
        chk(tag, pend, 1);
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        mem_stall = 1'b0;
        mem_done = 1'b0;
        mem_data = 16'h0000;
        dec_ready = 1'b1;
        lat = 1;
        lat_cnt = 0;
        stall_cnt = 0;
        pend = 1'b0;
        pend_want = 1'b0;
        pend_addr = 16'h0000;
        exp_pc = 16'h0000;
        rd_cnt = 0;
        pcen_cnt = 0;
        n_pop = 0;
        seen_rd = 1'b0;
        seen_addr = 16'h0000;
        last_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // first fetch from address 0
        seen_rd = 1'b0;
        for (int i = 0; i < 20 && n_pop < 1; i++) cycle();
        chk("t1_pop", n_pop, 1);
        chk("t1_first_addr", seen_addr, 16'h0000);

        // decode stalled: queue fills, issue stops
        dec_ready = 1'b0;
        for (int i = 0; i < 20 && sb.size() < 2; i++) cycle();
        chk("t2_full", sb.size(), 2);
        rd_cnt = 0;
        repeat (5) cycle();
        chk("t2_rd_low", rd_cnt, 0);
        chk("t2_head", inst, sb[0].inst);
        dec_ready = 1'b1;
        repeat (3) cycle();

        // memory stall at pc=4
        wait_idle("t3_idle_to");
        redirect = 1'b1;
        redirect_pc = 16'h0004;
        stall_cnt = 3;
        cycle();
        redirect = 1'b0;
        rd_cnt = 0;
        pcen_cnt = 0;
        seen_rd = 1'b0;
        wait_pend("t3_acc_to");
        chk("t3_rd_cycles", rd_cnt, 4);
        chk("t3_no_pcen", pcen_cnt, 0);
        chk("t3_addr", seen_addr, 16'h0004);
        for (int i = 0; i < 20 && pcen_cnt < 1; i++) cycle();
        chk("t3_pcen", pcen_cnt, 1);

        // redirect during WAIT, data returns later and is dropped
        lat = 2;
        wait_idle("t4_idle_to");
        wait_pend("t4_acc_to");
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        cycle();
        redirect = 1'b0;
        seen_rd = 1'b0;
        cycle();
        chk("t4_dropped", last_valid, 0);
        for (int i = 0; i < 20 && !seen_rd; i++) cycle();
        chk("t4_addr", seen_addr, 16'h0040);
        lat = 1;

        // redirect coinciding with mem_done
        wait_idle("t5_idle_to");
        for (int i = 0; i < 20 && !(pend && mem_done); i++) cycle();
        chk("t5_done_to", pend && mem_done, 1);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        cycle();
        redirect = 1'b0;
        seen_rd = 1'b0;
        cycle();
        chk("t5_valid", last_valid, 0);
        chk("t5_addr", seen_addr, 16'h0100);

        // wrap at 0xFFFE, then reset in WAIT
        wait_idle("t6_idle_to");
        dec_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 20 && sb.size() < 1; i++) cycle();
        chk("t6_pushed", sb.size(), 1);
        wait_pend("t6_acc_to");
        chk("t6_pc", pc, 16'h0000);
        chk("t6_head_inst", inst, mval(16'hFFFE));
        chk("t6_head_pc2", inst_pc2, 16'h0000);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t6_after_rst", last_valid, 0);
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
